// File: rtl/costas_pkg.sv
// Shared Costas-loop constants and fixed-point helpers. The arm low-pass
// filters reuse the same saturation/clamp helpers.
package costas_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned SUM_W  = WIDTH + 1;

  localparam int unsigned      DEF_ERR_SHIFT   = 31;
  localparam int unsigned      DEF_KP_SHIFT    = 8;
  localparam int unsigned      DEF_KI_SHIFT    = 16;
  localparam logic [WIDTH-1:0] DEF_INT_LIMIT   = 32'h3FFF_FFFF;
  localparam logic [WIDTH-1:0] DEF_LOCK_THRESH = 32'h0010_0000;
  localparam int unsigned      DEF_LOCK_COUNT  = 1024;

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Saturate a wide signed value into the signed WIDTH range.
  function automatic logic signed [WIDTH-1:0] sat_to_width(
    input logic signed [PROD_W-1:0] x
  );
    if (x > PROD_W'(SMAX)) return SMAX;
    if (x < PROD_W'(SMIN)) return SMIN;
    return WIDTH'(x);
  endfunction

  // Clamp a WIDTH+1 bit sum to the symmetric range [-lim, +lim].
  function automatic logic signed [WIDTH-1:0] clamp(
    input logic signed [SUM_W-1:0] x,
    input logic        [WIDTH-1:0] lim
  );
    logic signed [SUM_W-1:0] hi;
    hi = signed'({1'b0, lim});
    if (x > hi)  return WIDTH'(hi);
    if (x < -hi) return WIDTH'(-hi);
    return WIDTH'(x);
  endfunction

  // Magnitude with the most negative value folded onto the most positive.
  function automatic logic [WIDTH-1:0] abs_sat(
    input logic signed [WIDTH-1:0] x
  );
    if (x == SMIN) return SMAX;
    if (x < 0)     return -x;
    return x;
  endfunction

endpackage

// File: rtl/costas_loop_filter_if.sv
// Arm-sample input / NCO phase-increment output bundle of the loop filter.
interface costas_loop_filter_if;
  import costas_pkg::*;

  logic signed [WIDTH-1:0] i_in;
  logic signed [WIDTH-1:0] q_in;
  logic                    in_valid;
  logic                    clear_int;
  logic                    freeze;
  logic signed [WIDTH-1:0] phase_out;
  logic                    out_valid;
  logic signed [WIDTH-1:0] err_out;
  logic                    locked;

  modport master (
    output i_in, q_in, in_valid, clear_int, freeze,
    input  phase_out, out_valid, err_out, locked
  );

  modport slave (
    input  i_in, q_in, in_valid, clear_int, freeze,
    output phase_out, out_valid, err_out, locked
  );

endinterface

// File: rtl/costas_lock_detect.sv
// Carrier-lock indicator: run-length count of small phase-detector errors.
module costas_lock_detect
  import costas_pkg::*;
#(
  parameter logic [WIDTH-1:0] LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int unsigned      LOCK_COUNT  = DEF_LOCK_COUNT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] err_i,
  input  logic                    valid_i,
  input  logic                    clear_i,
  output logic                    locked_o
);

  localparam int unsigned      CNT_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             in_lock_c;

  // Any out-of-threshold sample restarts the run and drops lock at once.
  always_comb begin
    cnt_d     = cnt_q;
    locked_d  = locked_q;
    in_lock_c = (abs_sat(err_i) < LOCK_THRESH);
    if (clear_i) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (valid_i) begin
      if (in_lock_c) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        locked_d = (cnt_d == CNT_MAX);
      end else begin
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/costas_loop_filter.sv
// Costas-loop phase detector (I*Q) and PI loop filter driving the NCO
// phase increment; three-stage pipeline, one sample per cycle.
module costas_loop_filter
  import costas_pkg::*;
#(
  parameter int unsigned      ERR_SHIFT   = DEF_ERR_SHIFT,
  parameter int unsigned      KP_SHIFT    = DEF_KP_SHIFT,
  parameter int unsigned      KI_SHIFT    = DEF_KI_SHIFT,
  parameter logic [WIDTH-1:0] INT_LIMIT   = DEF_INT_LIMIT,
  parameter logic [WIDTH-1:0] LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int unsigned      LOCK_COUNT  = DEF_LOCK_COUNT
) (
  input logic                 clk,
  input logic                 rst_n,
  costas_loop_filter_if.slave bus_if
);

  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] prod_sh_c;
  logic signed [WIDTH-1:0]  err_c;
  logic signed [SUM_W-1:0]  integ_sum_c;
  logic signed [SUM_W-1:0]  phase_sum_c;

  logic signed [WIDTH-1:0] err_q,   err_d;
  logic signed [WIDTH-1:0] p_q,     p_d;
  logic signed [WIDTH-1:0] integ_q, integ_d;
  logic signed [WIDTH-1:0] phase_q, phase_d;
  logic                    v1_q, v1_d;
  logic                    v2_q, v2_d;
  logic                    out_valid_q, out_valid_d;
  logic                    locked_w;

  // Phase detector: full-precision product, scaled back to sample width.
  always_comb begin
    prod_c    = PROD_W'(bus_if.i_in) * PROD_W'(bus_if.q_in);
    prod_sh_c = prod_c >>> ERR_SHIFT;
    err_c     = sat_to_width(prod_sh_c);
  end

  // Each stage advances only on its own valid bit; clear_int acts regardless.
  always_comb begin
    err_d       = err_q;
    v1_d        = bus_if.in_valid;
    p_d         = p_q;
    integ_d     = integ_q;
    v2_d        = v1_q;
    phase_d     = phase_q;
    out_valid_d = v2_q;

    integ_sum_c = SUM_W'(integ_q) + SUM_W'(err_q >>> KI_SHIFT);
    phase_sum_c = SUM_W'(p_q) + SUM_W'(integ_q);

    if (bus_if.in_valid) err_d = err_c;

    if (v1_q) p_d = err_q >>> KP_SHIFT;

    if (bus_if.clear_int) begin
      integ_d = '0;
    end else if (v1_q && !bus_if.freeze) begin
      integ_d = clamp(integ_sum_c, INT_LIMIT);
    end

    if (v2_q) phase_d = sat_to_width(PROD_W'(phase_sum_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= '0;
      v1_q        <= 1'b0;
      p_q         <= '0;
      integ_q     <= '0;
      v2_q        <= 1'b0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      v1_q        <= v1_d;
      p_q         <= p_d;
      integ_q     <= integ_d;
      v2_q        <= v2_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
    end
  end

  costas_lock_detect #(
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT)
  ) u_lock (
    .clk      (clk),
    .rst_n    (rst_n),
    .err_i    (err_q),
    .valid_i  (v1_q),
    .clear_i  (bus_if.clear_int),
    .locked_o (locked_w)
  );

  assign bus_if.err_out   = err_q;
  assign bus_if.phase_out = phase_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.locked    = locked_w;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Self-checking bench for costas_loop_filter: per-sample reference model
// with an expected-output queue, directed scenarios plus random traffic.
module tb_costas_loop_filter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  costas_loop_filter_if bus();

  costas_loop_filter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  localparam longint SMAX_L = 64'sd2147483647;
  localparam longint SMIN_L = -SMAX_L - 64'sd1;
  localparam longint LIM_L  = 64'sd1073741823;
  localparam longint THR_L  = 64'sd1048576;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state: one pending sample waits for next cycle's
  // clear/freeze controls, then its filtered phase is due one cycle later.
  typedef struct { int due; longint ph; } exp_t;
  exp_t   exp_q[$];
  longint m_integ, m_err, m_last_ph, pend_err;
  bit     pend_v, m_locked;
  int     m_cnt;

  function automatic longint sat32(input longint x);
    if (x > SMAX_L) return SMAX_L;
    if (x < SMIN_L) return SMIN_L;
    return x;
  endfunction

  function automatic longint err_of(input int i, input int q);
    longint pr;
    pr = longint'(i) * longint'(q);
    return sat32(pr >>> 31);
  endfunction

  function automatic int rand_val();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return int'($urandom) >>> 20;
      2:       return ($urandom_range(0, 1) == 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
      default: return int'($urandom) >>> 6;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_integ = 0; m_err = 0; m_last_ph = 0; pend_err = 0;
    pend_v = 1'b0; m_locked = 1'b0; m_cnt = 0;
  endtask

  // Drive one cycle, advance the model, compare all outputs.
  task automatic step(input bit v, input int i, input int q, input bit clr, input bit frz);
    longint mag;
    bit     exp_ov;
    bus.in_valid = v; bus.i_in = i; bus.q_in = q;
    bus.clear_int = clr; bus.freeze = frz;
    @(posedge clk); #1;
    cyc++;
    if (clr) m_integ = 0;
    else if (pend_v && !frz) begin
      m_integ = m_integ + (pend_err >>> 16);
      if (m_integ > LIM_L) m_integ = LIM_L;
      if (m_integ < -LIM_L) m_integ = -LIM_L;
    end
    if (clr) begin
      m_cnt = 0; m_locked = 1'b0;
    end else if (pend_v) begin
      mag = (pend_err < 0) ? -pend_err : pend_err;
      if (mag > SMAX_L) mag = SMAX_L;
      if (mag < THR_L) begin
        if (m_cnt < 1024) m_cnt++;
        if (m_cnt == 1024) m_locked = 1'b1;
      end else begin
        m_cnt = 0; m_locked = 1'b0;
      end
    end
    if (pend_v) exp_q.push_back('{due: cyc + 1, ph: sat32((pend_err >>> 8) + m_integ)});
    pend_v = v;
    if (v) begin
      pend_err = err_of(i, q);
      m_err    = pend_err;
    end

    exp_ov = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (exp_ov) begin
      m_last_ph = exp_q[0].ph;
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (bus.err_out !== 32'(m_err)) begin
      n_errors++;
      $display("FAIL err_out cyc=%0d got=%0d exp=%0d", cyc, bus.err_out, m_err);
    end
    n_checks++;
    if (bus.locked !== m_locked) begin
      n_errors++;
      $display("FAIL locked cyc=%0d got=%b exp=%b", cyc, bus.locked, m_locked);
    end
    n_checks++;
    if (bus.out_valid !== exp_ov) begin
      n_errors++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_ov);
    end
    n_checks++;
    if (bus.phase_out !== 32'(m_last_ph)) begin
      n_errors++;
      $display("FAIL phase_out cyc=%0d got=%0d exp=%0d", cyc, bus.phase_out, m_last_ph);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.clear_int = 1'b0; bus.freeze = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_in = '0; bus.q_in = '0; bus.in_valid = 1'b0;
    bus.clear_int = 1'b0; bus.freeze = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if (bus.phase_out !== 32'd0 || bus.err_out !== 32'd0 ||
        bus.out_valid !== 1'b0 || bus.locked !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state got ph=%0d err=%0d ov=%b lk=%b exp all 0",
               bus.phase_out, bus.err_out, bus.out_valid, bus.locked);
    end
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 32'sh4000_0000, 32'sh4000_0000, 1'b0, 1'b0);
    n_checks++;
    if (bus.err_out !== 32'sd536870912) begin
      n_errors++;
      $display("FAIL single_err got=%0d exp=536870912", bus.err_out);
    end
    step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.phase_out !== 32'sd2105344) begin
      n_errors++;
      $display("FAIL single_phase got ov=%b ph=%0d exp ov=1 ph=2105344",
               bus.out_valid, bus.phase_out);
    end
    step(1'b0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_pulse got ov=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int exp_seq[4];
    int obs[7];
    exp_seq = '{2105344, 2113536, 2121728, 2129920};
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) step(1'b1, 32'sh4000_0000, 32'sh4000_0000, 1'b0, 1'b0);
      else        step(1'b0, 0, 0, 1'b0, 1'b0);
      obs[k] = bus.phase_out;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs[k+3] !== exp_seq[k]) begin
        n_errors++;
        $display("FAIL b2b_phase[%0d] got=%0d exp=%0d", k, obs[k+3], exp_seq[k]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 40000; k++) begin
      step(1'b1, 32'sh8000_0000, 32'sh8000_0000, 1'b0, 1'b0);
      if (bus.phase_out[31] !== 1'b0 && k > 3) begin
        n_checks++;
        n_errors++;
        $display("FAIL sat_wrap k=%0d got=%0d exp nonnegative", k, bus.phase_out);
      end
    end
    n_checks++;
    if (bus.err_out !== 32'sh7FFF_FFFF) begin
      n_errors++;
      $display("FAIL sat_err got=%h exp=7fffffff", bus.err_out);
    end
    n_checks++;
    if (bus.phase_out !== 32'sd1082130430) begin
      n_errors++;
      $display("FAIL sat_phase got=%0d exp=1082130430", bus.phase_out);
    end
  endtask

  task automatic test_freeze_clear();
    do_reset();
    step(1'b1, 32'sh4000_0000, 32'sh4000_0000, 1'b0, 1'b0);
    step(1'b1, 32'sh4000_0000, 32'sh4000_0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 32'sh4000_0000, 32'sh4000_0000, 1'b0, 1'b1);
    n_checks++;
    if (bus.phase_out !== 32'sd2105344) begin
      n_errors++;
      $display("FAIL freeze_phase got=%0d exp=2105344", bus.phase_out);
    end
    step(1'b1, 32'sh4000_0000, 32'sh4000_0000, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.phase_out !== 32'sd2097152) begin
      n_errors++;
      $display("FAIL clear_phase got ov=%b ph=%0d exp ov=1 ph=2097152",
               bus.out_valid, bus.phase_out);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 1024; k++) step(1'b1, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (bus.locked !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_early got=%b exp=0", bus.locked);
    end
    step(1'b1, 32'sh4000_0000, 32'sh4000_0000, 1'b0, 1'b0);
    n_checks++;
    if (bus.locked !== 1'b1) begin
      n_errors++;
      $display("FAIL lock_rise got=%b exp=1", bus.locked);
    end
    step(1'b0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (bus.locked !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_drop got=%b exp=0", bus.locked);
    end
    for (int k = 0; k < 1030; k++) step(1'b1, int'($urandom) >>> 22, int'($urandom) >>> 22, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    n_checks++;
    if (bus.locked !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_clear got=%b exp=0", bus.locked);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0, rand_val(), rand_val(),
           $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, rand_val(), rand_val(), 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.phase_out !== 32'd0 || bus.err_out !== 32'd0 ||
        bus.out_valid !== 1'b0 || bus.locked !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got ph=%0d err=%0d ov=%b lk=%b exp all 0",
               bus.phase_out, bus.err_out, bus.out_valid, bus.locked);
    end
    model_reset();
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 32'sh4000_0000, 32'sh4000_0000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_freeze_clear();
    test_lock();
    test_random();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
